// File: rtl/nmea_gga_time_parser.sv
// NMEA $xxGGA UTC time parser with XOR checksum check and PPS-aligned
// current-second time output.
//
// Ports:
//   SYS_CLK, SYS_RST_N          system clock, asynchronous active-low reset
//   rx_data[7:0], rx_valid      byte stream from the UART receiver (no backpressure)
//   pps_in                      raw asynchronous PPS input
//   gga_hh/mm/ss, gga_valid     time of the last valid sentence, update pulse
//   cks_err                     sentence complete but checksum mismatched
//   utc_hh/mm/ss, pps_tick      PPS-aligned time, synchronised PPS pulse
//   time_locked                 set once a parsed time has been applied at a PPS
module nmea_gga_time_parser #(
    parameter int PPS_SYNC_STAGES = 2,
    parameter int PPS_ADD_SECOND  = 1,
    parameter int MAX_SENT_LEN    = 82
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST_N,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       pps_in,
    output logic [4:0] gga_hh,
    output logic [5:0] gga_mm,
    output logic [5:0] gga_ss,
    output logic       gga_valid,
    output logic       cks_err,
    output logic [4:0] utc_hh,
    output logic [5:0] utc_mm,
    output logic [5:0] utc_ss,
    output logic       pps_tick,
    output logic       time_locked
);

    localparam int LW = $clog2(MAX_SENT_LEN + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEP,
        S_TIME,
        S_SKIP,
        S_CK1,
        S_CK2
    } state_t;

    typedef struct packed {
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
    } hms_t;

    // One-second advance with minute/hour/day wrap.
    function automatic hms_t hms_inc(input hms_t t);
        hms_t r;
        r = t;
        if (t.ss == 6'd59) begin
            r.ss = '0;
            if (t.mm == 6'd59) begin
                r.mm = '0;
                r.hh = (t.hh == 5'd23) ? 5'd0 : t.hh + 5'd1;
            end else begin
                r.mm = t.mm + 6'd1;
            end
        end else begin
            r.ss = t.ss + 6'd1;
        end
        return r;
    endfunction

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] len_cnt;
    logic [LW-1:0] len_nxt;
    logic          len_over;
    logic [2:0]    idx;
    logic [7:0]    acc;
    logic [19:0]   bcd;
    logic [3:0]    ck_hi;
    hms_t          pend;
    logic          in_sent;

    logic          is_dollar;
    logic          is_star;
    logic          is_comma;
    logic          is_digit;
    logic          is_hex;
    logic [3:0]    hex_val;
    logic          hdr_ok;
    logic          range_ok;
    logic [4:0]    hh_bin;
    logic [5:0]    mm_bin;
    logic [5:0]    ss_bin;

    logic          acc_en;
    logic          time_last;
    logic          sent_ok;
    logic          sent_bad;

    logic [PPS_SYNC_STAGES-1:0] pps_sync;
    logic          pps_prev;
    logic          pps_rise;
    logic          fresh;
    hms_t          gga_cur;
    hms_t          utc_cur;

    // Character classes of the incoming byte.
    assign is_dollar = (rx_data == 8'h24);
    assign is_star   = (rx_data == 8'h2A);
    assign is_comma  = (rx_data == 8'h2C);
    assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_hex    = is_digit || ((rx_data >= 8'h41) && (rx_data <= 8'h46));
    // 'A'..'F' have low nibble 1..6, so +9 yields 10..15.
    assign hex_val   = is_digit ? rx_data[3:0] : rx_data[3:0] + 4'd9;

    assign in_sent  = (state != S_IDLE);
    assign len_nxt  = len_cnt + LW'(1);
    assign len_over = (len_nxt > LW'(MAX_SENT_LEN));

    // Header positions 0-1 are the talker id; 2-4 must spell GGA.
    always_comb begin
        case (idx)
            3'd2, 3'd3: hdr_ok = (rx_data == 8'h47);
            3'd4:       hdr_ok = (rx_data == 8'h41);
            default:    hdr_ok = 1'b1;
        endcase
    end

    // bcd holds the first five digits; the sixth is the current byte.
    // Digits are already known to be 0-9, so tens limits suffice.
    assign range_ok = ((bcd[19:16] < 4'd2) ||
                       ((bcd[19:16] == 4'd2) && (bcd[15:12] <= 4'd3))) &&
                      (bcd[11:8] <= 4'd5) &&
                      (bcd[3:0] <= 4'd5);

    assign hh_bin = 5'(bcd[19:16]) * 5'd10 + 5'(bcd[15:12]);
    assign mm_bin = 6'(bcd[11:8]) * 6'd10 + 6'(bcd[7:4]);
    assign ss_bin = 6'(bcd[3:0]) * 6'd10 + 6'(rx_data[3:0]);

    // FSM state register.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state.
    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            if (is_dollar) begin
                state_nxt = S_HDR;
            end else if (in_sent && len_over) begin
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_HDR: begin
                        if (!hdr_ok) begin
                            state_nxt = S_IDLE;
                        end else if (idx == 3'd4) begin
                            state_nxt = S_SEP;
                        end
                    end
                    S_SEP: begin
                        state_nxt = is_comma ? S_TIME : S_IDLE;
                    end
                    S_TIME: begin
                        if (idx < 3'd6) begin
                            if (!is_digit || ((idx == 3'd5) && !range_ok)) begin
                                state_nxt = S_IDLE;
                            end
                        end else if (is_comma) begin
                            state_nxt = S_SKIP;
                        end else if (is_star) begin
                            state_nxt = S_CK1;
                        end
                    end
                    S_SKIP: begin
                        if (is_star) begin
                            state_nxt = S_CK1;
                        end
                    end
                    S_CK1: begin
                        state_nxt = is_hex ? S_CK2 : S_IDLE;
                    end
                    default: begin
                        state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    // FSM outputs: datapath enables and sentence-complete decode.
    always_comb begin
        acc_en    = 1'b0;
        time_last = 1'b0;
        sent_ok   = 1'b0;
        sent_bad  = 1'b0;
        if (rx_valid && !is_dollar && in_sent && !len_over) begin
            case (state)
                S_HDR, S_SEP, S_SKIP: begin
                    acc_en = !is_star;
                end
                S_TIME: begin
                    acc_en    = !is_star;
                    time_last = (idx == 3'd5) && is_digit;
                end
                S_CK2: begin
                    if (is_hex) begin
                        sent_ok  = ({ck_hi, hex_val} == acc);
                        sent_bad = ({ck_hi, hex_val} != acc);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Parse datapath: length, checksum, digit capture.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            len_cnt <= '0;
            idx     <= '0;
            acc     <= '0;
            bcd     <= '0;
            ck_hi   <= '0;
            pend    <= '0;
        end else if (rx_valid) begin
            if (is_dollar) begin
                len_cnt <= LW'(1);
                idx     <= '0;
                acc     <= '0;
            end else if (in_sent) begin
                len_cnt <= len_nxt;
                if (acc_en) begin
                    acc <= acc ^ rx_data;
                end
                if (state == S_SEP) begin
                    idx <= '0;
                end else if ((state == S_HDR) ||
                             ((state == S_TIME) && (idx < 3'd6))) begin
                    idx <= idx + 3'd1;
                end
                if ((state == S_TIME) && (idx < 3'd6)) begin
                    bcd <= {bcd[15:0], rx_data[3:0]};
                end
                if (time_last) begin
                    pend <= {hh_bin, mm_bin, ss_bin};
                end
                if (state == S_CK1) begin
                    ck_hi <= hex_val;
                end
            end
        end
    end

    // Parsed time outputs and result pulses.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            gga_valid <= 1'b0;
            cks_err   <= 1'b0;
            gga_hh    <= '0;
            gga_mm    <= '0;
            gga_ss    <= '0;
        end else begin
            gga_valid <= sent_ok;
            cks_err   <= sent_bad;
            if (sent_ok) begin
                {gga_hh, gga_mm, gga_ss} <= pend;
            end
        end
    end

    // PPS synchroniser and rising-edge detect.
    assign pps_rise = pps_sync[PPS_SYNC_STAGES-1] && !pps_prev;
    assign gga_cur  = {gga_hh, gga_mm, gga_ss};
    assign utc_cur  = {utc_hh, utc_mm, utc_ss};

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            pps_sync <= '0;
            pps_prev <= 1'b0;
            pps_tick <= 1'b0;
        end else begin
            pps_sync <= {pps_sync[PPS_SYNC_STAGES-2:0], pps_in};
            pps_prev <= pps_sync[PPS_SYNC_STAGES-1];
            pps_tick <= pps_rise;
        end
    end

    // A PPS edge sees the gga/fresh state from before any coincident
    // sentence; that sentence then re-arms fresh for the following PPS.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            fresh       <= 1'b0;
            time_locked <= 1'b0;
            utc_hh      <= '0;
            utc_mm      <= '0;
            utc_ss      <= '0;
        end else begin
            if (sent_ok) begin
                fresh <= 1'b1;
            end else if (pps_rise) begin
                fresh <= 1'b0;
            end
            if (pps_rise) begin
                if (fresh) begin
                    time_locked <= 1'b1;
                    if (PPS_ADD_SECOND != 0) begin
                        {utc_hh, utc_mm, utc_ss} <= hms_inc(gga_cur);
                    end else begin
                        {utc_hh, utc_mm, utc_ss} <= gga_cur;
                    end
                end else if (time_locked) begin
                    {utc_hh, utc_mm, utc_ss} <= hms_inc(utc_cur);
                end
            end
        end
    end

endmodule

// File: tb/tb_nmea_gga_time_parser.sv
// Self-checking bench for nmea_gga_time_parser: sentence-level model
// plus per-cycle output comparison and literal spot checks.
module tb_nmea_gga_time_parser;

    localparam int STAGES = 2;
    localparam int MAXL   = 82;

    logic       SYS_CLK   = 1'b0;
    logic       SYS_RST_N = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       rx_valid  = 1'b0;
    logic       pps_in    = 1'b0;
    logic [4:0] gga_hh;
    logic [5:0] gga_mm;
    logic [5:0] gga_ss;
    logic       gga_valid;
    logic       cks_err;
    logic [4:0] utc_hh;
    logic [5:0] utc_mm;
    logic [5:0] utc_ss;
    logic       pps_tick;
    logic       time_locked;

    nmea_gga_time_parser #(
        .PPS_SYNC_STAGES(STAGES),
        .PPS_ADD_SECOND (1),
        .MAX_SENT_LEN   (MAXL)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .SYS_RST_N  (SYS_RST_N),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .pps_in     (pps_in),
        .gga_hh     (gga_hh),
        .gga_mm     (gga_mm),
        .gga_ss     (gga_ss),
        .gga_valid  (gga_valid),
        .cks_err    (cks_err),
        .utc_hh     (utc_hh),
        .utc_mm     (utc_mm),
        .utc_ss     (utc_ss),
        .pps_tick   (pps_tick),
        .time_locked(time_locked)
    );

    always #12 SYS_CLK = ~SYS_CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: times kept as seconds of day.
    int cyc     = 0;
    int gv_cyc  = -1;
    int ce_cyc  = -1;
    int pps_cyc = -1;
    int n_gga   = 0;
    int m_gga   = 0;
    int m_utc   = 0;
    bit m_fresh  = 1'b0;
    bit m_locked = 1'b0;
    bit exp_gv   = 1'b0;
    bit exp_ce   = 1'b0;
    bit exp_tick = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [16:0] hms(input int s);
        return {5'(s / 3600), 6'((s / 60) % 60), 6'(s % 60)};
    endfunction

    function automatic int hv(input byte c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    function automatic bit isdig(input byte c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic string mk(input string body);
        byte x;
        x = 8'h00;
        for (int i = 0; i < body.len(); i++) x = x ^ body[i];
        return {"$", body, "*", $sformatf("%02X", x)};
    endfunction

    // Outcome of a byte stream: kind 0 none, 1 valid, 2 checksum error;
    // ck = stream index of the 2nd checksum char; secs = parsed time.
    function automatic void eval(input string s, output int kind,
                                 output int ck, output int secs);
        int d, st, hh, mm, ss;
        byte x;
        string t;
        kind = 0;
        ck   = -1;
        secs = 0;
        d    = -1;
        for (int i = 0; i < s.len(); i++) if (s[i] == "$") d = i;
        if (d < 0) return;
        t = s.substr(d, s.len() - 1);
        if (t.len() < 16) return;
        if (t.substr(3, 5) != "GGA" || t[6] != ",") return;
        for (int i = 7; i < 13; i++) if (!isdig(t[i])) return;
        hh = (int'(t[7]) - 48) * 10 + int'(t[8]) - 48;
        mm = (int'(t[9]) - 48) * 10 + int'(t[10]) - 48;
        ss = (int'(t[11]) - 48) * 10 + int'(t[12]) - 48;
        if (hh > 23 || mm > 59 || ss > 59) return;
        st = -1;
        for (int i = 13; i < t.len(); i++) begin
            if (t[i] == "*") begin
                st = i;
                break;
            end
        end
        if (st < 0 || st + 2 >= t.len()) return;
        if (st + 3 > MAXL) return;
        if (hv(t[st+1]) < 0 || hv(t[st+2]) < 0) return;
        x = 8'h00;
        for (int i = 1; i < st; i++) x = x ^ t[i];
        ck   = d + st + 2;
        secs = hh * 3600 + mm * 60 + ss;
        kind = ((hv(t[st+1]) * 16 + hv(t[st+2])) == int'(x)) ? 1 : 2;
    endfunction

    // Behavioural model, advanced once per clock.
    initial begin
        forever begin
            @(posedge SYS_CLK or negedge SYS_RST_N);
            if (!SYS_RST_N) begin
                gv_cyc   = -1;
                ce_cyc   = -1;
                pps_cyc  = -1;
                m_gga    = 0;
                m_utc    = 0;
                m_fresh  = 1'b0;
                m_locked = 1'b0;
                exp_gv   = 1'b0;
                exp_ce   = 1'b0;
                exp_tick = 1'b0;
            end else begin
                cyc++;
                exp_gv   = (cyc == gv_cyc);
                exp_ce   = (cyc == ce_cyc);
                exp_tick = (cyc == pps_cyc);
                if (exp_tick) begin
                    if (m_fresh) begin
                        m_utc    = (m_gga + 1) % 86400;
                        m_locked = 1'b1;
                        m_fresh  = 1'b0;
                    end else if (m_locked) begin
                        m_utc = (m_utc + 1) % 86400;
                    end
                end
                if (exp_gv) begin
                    m_gga   = n_gga;
                    m_fresh = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge SYS_CLK);
            chk("gga_valid", 32'(gga_valid), 32'(exp_gv));
            chk("cks_err", 32'(cks_err), 32'(exp_ce));
            chk("pps_tick", 32'(pps_tick), 32'(exp_tick));
            chk("time_locked", 32'(time_locked), 32'(m_locked));
            chk("gga_hms", 32'({gga_hh, gga_mm, gga_ss}), 32'(hms(m_gga)));
            chk("utc_hms", 32'({utc_hh, utc_mm, utc_ss}), 32'(hms(m_utc)));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge SYS_CLK);
            #1;
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    task automatic send_stream(input string s, input int gap, input int pps_at);
        int kind, ck, secs;
        eval(s, kind, ck, secs);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge SYS_CLK);
            #1;
            rx_data  = s[i];
            rx_valid = 1'b1;
            if (i == ck) begin
                if (kind == 1) begin
                    gv_cyc = cyc + 1;
                    n_gga  = secs;
                end else if (kind == 2) begin
                    ce_cyc = cyc + 1;
                end
            end
            if (i == pps_at) begin
                pps_in  = 1'b1;
                pps_cyc = cyc + 1 + STAGES;
            end
            if (gap > 0) idle(gap);
        end
        idle(5);
        pps_in = 1'b0;
        idle(5);
    endtask

    task automatic pps_pulse();
        @(posedge SYS_CLK);
        #1;
        pps_in  = 1'b1;
        pps_cyc = cyc + 1 + STAGES;
        idle(6);
        pps_in = 1'b0;
        idle(6);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        string s, b;
        int    kind, ck, secs, p;
        byte   c;

        idle(4);
        chk("rst_gga", 32'({gga_hh, gga_mm, gga_ss, gga_valid, cks_err}), 0);
        chk("rst_utc", 32'({utc_hh, utc_mm, utc_ss, pps_tick, time_locked}), 0);
        SYS_RST_N = 1'b1;
        idle(3);

        // PPS before any sentence: tick only, time stays 0, unlocked.
        pps_pulse();
        chk("pre_lock", 32'(time_locked), 0);

        // 1: valid sentence
        b = "GPGGA,102015.00,4717.11399,N,00833.91590,E,1,08,1.01,499.6,M,48.0,M,,";
        s = mk(b);
        send_stream({s, "\r\n"}, 0, -1);
        chk("t1_hh", 32'(gga_hh), 10);
        chk("t1_mm", 32'(gga_mm), 20);
        chk("t1_ss", 32'(gga_ss), 15);

        // 2: corrupted 2nd checksum char, with idle gaps between bytes
        p = s.len() - 1;
        c = s[p];
        c = (c == "0") ? "1" : "0";
        s.putc(p, c);
        send_stream({s, "\r\n"}, 1, -1);
        chk("t2_hh", 32'(gga_hh), 10);
        chk("t2_utc", 32'({utc_hh, utc_mm, utc_ss}), 0);

        // 3: PPS applies parsed time + 1 s, then free-runs
        pps_pulse();
        chk("t3_utc1", 32'({utc_hh, utc_mm, utc_ss}), 32'({5'd10, 6'd20, 6'd16}));
        chk("t3_lock", 32'(time_locked), 1);
        pps_pulse();
        chk("t3_utc2", 32'({utc_hh, utc_mm, utc_ss}), 32'({5'd10, 6'd20, 6'd17}));

        // 4: day wrap, then out-of-range fields abort silently
        send_stream({mk("GNGGA,235959.00,,,,,0,,,,,,,,"), "\r\n"}, 0, -1);
        pps_pulse();
        chk("t4_wrap", 32'({utc_hh, utc_mm, utc_ss}), 0);
        send_stream(mk("GPGGA,246000,,,,,"), 0, -1);
        send_stream(mk("GPGGA,236000,,,,,"), 0, -1);
        send_stream(mk("GPGGA,235960,,,,,"), 0, -1);
        send_stream(mk("GPGGA,12a456,,,,,"), 0, -1);
        chk("t4_hold", 32'({gga_hh, gga_mm, gga_ss}), 32'({5'd23, 6'd59, 6'd59}));

        // 5: restart on '$', RMC ignored, length limit
        send_stream({"$GPGGA,1122", mk("GPGGA,070809.5,x,y")}, 0, -1);
        chk("t5_restart", 32'({gga_hh, gga_mm, gga_ss}), 32'({5'd7, 6'd8, 6'd9}));
        send_stream(mk("GPRMC,123519,A,4807.038,N"), 0, -1);
        b = "$GPGGA,010203,";
        while (b.len() < 90) b = {b, "A"};
        send_stream({b, "*00\r\n"}, 0, -1);
        b = "GPGGA,121314,";
        while (b.len() < 78) b = {b, "A"};
        send_stream(mk(b), 0, -1);
        chk("t5_len82", 32'({gga_hh, gga_mm, gga_ss}), 32'({5'd12, 6'd13, 6'd14}));
        b = "GPGGA,131415,";
        while (b.len() < 79) b = {b, "A"};
        send_stream(mk(b), 0, -1);
        chk("t5_len83", 32'({gga_hh, gga_mm, gga_ss}), 32'({5'd12, 6'd13, 6'd14}));
        pps_pulse();
        chk("t5_utc", 32'({utc_hh, utc_mm, utc_ss}), 32'({5'd12, 6'd13, 6'd15}));

        // 6: reset mid-TIME, recovery, coincident sentence and PPS
        send_stream("$GPGGA,10", 0, -1);
        #5;
        SYS_RST_N = 1'b0;
        idle(3);
        chk("t6_rst_gga", 32'({gga_hh, gga_mm, gga_ss, gga_valid, cks_err}), 0);
        chk("t6_rst_utc", 32'({utc_hh, utc_mm, utc_ss, pps_tick, time_locked}), 0);
        SYS_RST_N = 1'b1;
        idle(2);
        send_stream(mk("GPGGA,050607,,,,,"), 0, -1);
        chk("t6_gga", 32'({gga_hh, gga_mm, gga_ss}), 32'({5'd5, 6'd6, 6'd7}));
        s = mk("GPGGA,080910.00,,,,,");
        eval(s, kind, ck, secs);
        send_stream(s, 0, ck - 2);
        chk("t6_coinc_utc", 32'({utc_hh, utc_mm, utc_ss}), 32'({5'd5, 6'd6, 6'd8}));
        chk("t6_coinc_gga", 32'({gga_hh, gga_mm, gga_ss}), 32'({5'd8, 6'd9, 6'd10}));
        pps_pulse();
        chk("t6_next_utc", 32'({utc_hh, utc_mm, utc_ss}), 32'({5'd8, 6'd9, 6'd11}));

        idle(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
